// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-encoder blocks: scheduler state
// encoding, channel-index width and saturating word arithmetic.
package snn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_EMIT = 2'd2,
        S_WB   = 2'd3
    } sched_state_e;

    localparam int SNN_W = 32;
    typedef logic [SNN_W-1:0] snn_word_t;

    // Channel index width; a single channel still needs one index bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic snn_word_t sat_add(input snn_word_t a, input snn_word_t b);
        logic [SNN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SNN_W] ? '1 : s[SNN_W-1:0];
    endfunction

    function automatic snn_word_t sat_sub(input snn_word_t a, input snn_word_t b);
        return (a < b) ? '0 : a - b;
    endfunction

endpackage

// File: rtl/spike_encoder_sched_if.sv
// Sample-in / config / spike-out bundle of the spike encoder scheduler.
interface spike_encoder_sched_if
    import snn_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32
) ();
    localparam int CH_W = ch_w(N_CH);

    // Handshakes: a sample on channel k transfers in the cycle smp_ready_o[k]
    // is high (valid may drop at any time before that, nothing is remembered);
    // an event transfers when evt_valid_o & evt_ready_i, and evt_* hold steady
    // while evt_valid_o is high and evt_ready_i is low.
    logic [N_CH-1:0]        smp_valid_i;
    logic [N_CH*DATA_W-1:0] smp_data_i;
    logic [N_CH-1:0]        smp_ready_o;
    logic [DATA_W-1:0]      delta_i;
    logic                   cfg_we_i;
    logic [CH_W-1:0]        cfg_ch_i;
    logic [DATA_W-1:0]      cfg_thr_i;
    logic                   evt_valid_o;
    logic                   evt_ready_i;
    logic [CH_W-1:0]        evt_ch_o;
    logic                   evt_pol_o;
    logic                   busy_o;
    sched_state_e           state_o;

    modport master (
        output smp_valid_i, smp_data_i, delta_i, cfg_we_i, cfg_ch_i, cfg_thr_i, evt_ready_i,
        input  smp_ready_o, evt_valid_o, evt_ch_o, evt_pol_o, busy_o, state_o
    );

    modport slave (
        input  smp_valid_i, smp_data_i, delta_i, cfg_we_i, cfg_ch_i, cfg_thr_i, evt_ready_i,
        output smp_ready_o, evt_valid_o, evt_ch_o, evt_pol_o, busy_o, state_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping around.
module rr_arbiter
    import snn_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = ch_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int i);
        int k;
        k = int'(p) + i;
        if (k >= N) k = k - N;
        return IW'(k);
    endfunction

    always_comb begin
        logic [IW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = wrap_idx(ptr, i);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/spike_encoder_sched.sv
// Delta-threshold spike encoder shared round-robin across N_CH channels;
// per-channel upper/lower thresholds adapt after every spike.
module spike_encoder_sched
    import snn_pkg::*;
#(
    parameter int                N_CH        = 4,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] DEFAULT_THR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    spike_encoder_sched_if.slave  bus
);

    localparam int CH_W = ch_w(N_CH);

    sched_state_e      state_q;
    logic [CH_W-1:0]   ptr_q, g_q;
    logic [DATA_W-1:0] smp_q, delta_q, new_u_q, new_l_q;
    logic              wr_q;
    logic              evt_valid_q, evt_pol_q;
    logic [CH_W-1:0]   evt_ch_q;

    logic [DATA_W-1:0] uthr_q [N_CH];
    logic [DATA_W-1:0] lthr_q [N_CH];

    logic [N_CH-1:0]   gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] smp_sel;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req     (bus.smp_valid_i),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_comb begin
        smp_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt[k]) smp_sel = bus.smp_data_i[k*DATA_W +: DATA_W];
        end
    end

    // Decision datapath; only meaningful while in S_CALC.
    logic [DATA_W-1:0] u_rd, l_rd, calc_add, calc_sub;
    logic [DATA_W:0]   add_full;
    logic              calc_up, calc_dn;

    assign u_rd     = uthr_q[g_q];
    assign l_rd     = lthr_q[g_q];
    assign add_full = {1'b0, u_rd} + {1'b0, delta_q};
    assign calc_add = add_full[DATA_W] ? '1 : add_full[DATA_W-1:0];
    assign calc_sub = (l_rd < delta_q) ? '0 : l_rd - delta_q;
    assign calc_up  = (smp_q >= calc_add);
    assign calc_dn  = !calc_up && (smp_q <= calc_sub);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            smp_q       <= '0;
            delta_q     <= '0;
            new_u_q     <= '0;
            new_l_q     <= '0;
            wr_q        <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_pol_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any) begin
                        g_q     <= gnt_idx;
                        smp_q   <= smp_sel;
                        delta_q <= bus.delta_i;
                        ptr_q   <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Thresholds are captured now so later config writes cannot
                    // change the event already decided.
                    wr_q      <= calc_up | calc_dn;
                    new_u_q   <= calc_up ? calc_add : l_rd;
                    new_l_q   <= calc_up ? u_rd : calc_sub;
                    evt_ch_q  <= g_q;
                    evt_pol_q <= calc_up;
                    if (calc_up || calc_dn) begin
                        evt_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_EMIT: begin
                    if (bus.evt_ready_i) begin
                        evt_valid_q <= 1'b0;
                        state_q     <= S_WB;
                    end
                end
                S_WB:    state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Config has priority over the write-back to the same channel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_CH; k++) begin
                uthr_q[k] <= DEFAULT_THR;
                lthr_q[k] <= DEFAULT_THR;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (bus.cfg_we_i && bus.cfg_ch_i == CH_W'(k)) begin
                    uthr_q[k] <= bus.cfg_thr_i;
                    lthr_q[k] <= bus.cfg_thr_i;
                end else if (state_q == S_WB && wr_q && g_q == CH_W'(k)) begin
                    uthr_q[k] <= new_u_q;
                    lthr_q[k] <= new_l_q;
                end
            end
        end
    end

    assign bus.smp_ready_o = (state_q == S_IDLE) ? gnt : '0;
    assign bus.evt_valid_o = evt_valid_q;
    assign bus.evt_ch_o    = evt_ch_q;
    assign bus.evt_pol_o   = evt_pol_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_spike_encoder_sched.sv
// Directed bench for spike_encoder_sched with a cycle model and event scoreboard.
module tb_spike_encoder_sched;
    import snn_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    spike_encoder_sched_if #(.N_CH(N), .DATA_W(W)) bus ();

    spike_encoder_sched #(.N_CH(N), .DATA_W(W), .DEFAULT_THR(32'd0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [CW:0]   exp_q[$];
    logic [CW:0]   evt_log[$];
    int            grant_log[$];
    sched_state_e  m_state;
    logic [CW-1:0] m_ptr, m_g;
    logic [W-1:0]  m_u [N];
    logic [W-1:0]  m_l [N];
    logic [W-1:0]  m_smp, m_delta, m_nu, m_nl;
    logic          m_wr;
    logic          prev_hold;
    logic [CW:0]   prev_evt;
    int            n_acc = 0;
    int            n_evt = 0;

    task model_reset();
        m_state   = S_IDLE;
        m_ptr     = '0;
        m_g       = '0;
        m_wr      = 1'b0;
        prev_hold = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_u[k] = '0;
            m_l[k] = '0;
        end
        exp_q.delete();
        grant_log.delete();
    endtask

    function automatic logic [3:0] last_evt();
        if (evt_log.size() == 0) return 4'hF;
        return {1'b0, evt_log[evt_log.size()-1]};
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] exp_gnt;
        logic [W:0]   s;
        logic [W-1:0] add, sub, u, l;
        logic         up, dn, found;
        logic [CW:0]  exp_evt;
        int           k;
        if (!rst_n) begin
            model_reset();
        end else begin
            check("busy", bus.busy_o, m_state != S_IDLE);
            check("state", bus.state_o, m_state);
            check("evt_valid", bus.evt_valid_o, m_state == S_EMIT);
            if (prev_hold) check("evt_stable", {bus.evt_ch_o, bus.evt_pol_o}, prev_evt);
            prev_hold = bus.evt_valid_o && !bus.evt_ready_i;
            prev_evt  = {bus.evt_ch_o, bus.evt_pol_o};
            exp_gnt   = '0;
            case (m_state)
                S_IDLE: begin
                    found = 1'b0;
                    k     = 0;
                    for (int i = 0; i < N; i++) begin
                        if (!found && bus.smp_valid_i[(int'(m_ptr) + i) % N]) begin
                            found = 1'b1;
                            k     = (int'(m_ptr) + i) % N;
                        end
                    end
                    if (found) exp_gnt[k] = 1'b1;
                    check("smp_ready", bus.smp_ready_o, exp_gnt);
                    if (found) begin
                        m_g     = CW'(k);
                        m_smp   = bus.smp_data_i[k*W +: W];
                        m_delta = bus.delta_i;
                        m_ptr   = CW'((k + 1) % N);
                        n_acc++;
                        grant_log.push_back(k);
                        m_state = S_CALC;
                    end
                end
                S_CALC: begin
                    check("ready_calc", bus.smp_ready_o, exp_gnt);
                    u   = m_u[m_g];
                    l   = m_l[m_g];
                    s   = {1'b0, u} + {1'b0, m_delta};
                    add = s[W] ? {W{1'b1}} : s[W-1:0];
                    sub = (l < m_delta) ? '0 : l - m_delta;
                    up  = (m_smp >= add);
                    dn  = !up && (m_smp <= sub);
                    m_wr = up | dn;
                    m_nu = up ? add : l;
                    m_nl = up ? u : sub;
                    if (m_wr) begin
                        exp_q.push_back({m_g, up});
                        m_state = S_EMIT;
                    end else begin
                        m_state = S_WB;
                    end
                end
                S_EMIT: begin
                    check("ready_emit", bus.smp_ready_o, exp_gnt);
                    if (bus.evt_ready_i) begin
                        if (exp_q.size() == 0) begin
                            check("evt_unexpected", 1'b1, 1'b0);
                        end else begin
                            exp_evt = exp_q.pop_front();
                            check("evt_data", {bus.evt_ch_o, bus.evt_pol_o}, exp_evt);
                        end
                        evt_log.push_back({bus.evt_ch_o, bus.evt_pol_o});
                        n_evt++;
                        m_state = S_WB;
                    end
                end
                default: begin
                    check("ready_wb", bus.smp_ready_o, exp_gnt);
                    if (m_wr) begin
                        m_u[m_g] = m_nu;
                        m_l[m_g] = m_nl;
                    end
                    m_state = S_IDLE;
                end
            endcase
            if (bus.cfg_we_i && int'(bus.cfg_ch_i) < N) begin
                m_u[bus.cfg_ch_i] = bus.cfg_thr_i;
                m_l[bus.cfg_ch_i] = bus.cfg_thr_i;
            end
        end
    end

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [W-1:0] d, input logic [W-1:0] dl);
        bus.smp_valid_i[ch]        = 1'b1;
        bus.smp_data_i[ch*W +: W] = d;
        bus.delta_i                = dl;
        cyc(1);
        bus.smp_valid_i[ch] = 1'b0;
    endtask

    task automatic cfg(input int ch, input logic [W-1:0] thr);
        bus.cfg_we_i  = 1'b1;
        bus.cfg_ch_i  = CW'(ch);
        bus.cfg_thr_i = thr;
        cyc(1);
        bus.cfg_we_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        int e0, a0;
        bus.smp_valid_i = '0;
        bus.smp_data_i  = '0;
        bus.delta_i     = '0;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_ch_i    = '0;
        bus.cfg_thr_i   = '0;
        bus.evt_ready_i = 1'b1;

        cyc(3);
        check("rst_ready", bus.smp_ready_o, 0);
        check("rst_evt_valid", bus.evt_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_evt_ch", bus.evt_ch_o, 0);
        check("rst_evt_pol", bus.evt_pol_o, 0);
        check("rst_state", bus.state_o, S_IDLE);
        rst_n = 1'b1;
        cyc(2);

        // Up spike from default thresholds
        send(0, 32'd10, 32'd10);
        cyc(6);
        check("t1_evt_cnt", n_evt, 1);
        check("t1_evt", last_evt(), 4'b0001);

        // Sample inside the band: no event
        send(0, 32'd5, 32'd10);
        cyc(5);
        check("t2_evt_cnt", n_evt, 1);
        check("t2_acc_cnt", n_acc, 2);

        // Down spike after preload, then probe the new lower threshold
        cfg(1, 32'd100);
        send(1, 32'd80, 32'd10);
        cyc(6);
        check("t3_evt_cnt", n_evt, 2);
        check("t3_evt", last_evt(), 4'b0010);
        send(1, 32'd91, 32'd0);
        cyc(6);
        check("t3_lthr_probe", n_evt, 2);

        // Round robin with every channel requesting
        do_reset();
        bus.delta_i     = W'($urandom_range(0, 50));
        bus.smp_valid_i = '1;
        for (int c = 0; c < 60 && grant_log.size() < 5; c++) begin
            for (int ch = 0; ch < N; ch++) bus.smp_data_i[ch*W +: W] = W'($urandom_range(0, 300));
            cyc(1);
        end
        bus.smp_valid_i = '0;
        cyc(6);
        check("t4_grant_cnt", grant_log.size() >= 5, 1'b1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) check("t4_order", grant_log[i], i % N);

        // Back-pressure: event held, no new accept
        e0 = n_evt;
        bus.evt_ready_i = 1'b0;
        cfg(2, 32'd0);
        a0 = n_acc;
        send(2, 32'd200, 32'd10);
        bus.smp_valid_i[3]       = 1'b1;
        bus.smp_data_i[3*W +: W] = 32'd5;
        cyc(6);
        check("t5_held_valid", bus.evt_valid_o, 1'b1);
        check("t5_held_pol", bus.evt_pol_o, 1'b1);
        check("t5_no_accept", n_acc, a0 + 1);
        check("t5_no_evt", n_evt, e0);
        bus.smp_valid_i[3] = 1'b0;
        bus.evt_ready_i    = 1'b1;
        cyc(4);
        check("t5_evt_cnt", n_evt, e0 + 1);

        // Saturation at the top of the range
        e0 = n_evt;
        cfg(3, {W{1'b1}});
        send(3, {W{1'b1}}, 32'd1);
        cyc(6);
        send(3, {W{1'b1}}, 32'd0);
        cyc(6);
        check("t6_evt_cnt", n_evt, e0 + 2);
        check("t6_evt", last_evt(), 4'b0111);

        // Config write landing in the write-back cycle
        cfg(2, 32'd0);
        cyc(2);
        bus.smp_valid_i[2]       = 1'b1;
        bus.smp_data_i[2*W +: W] = 32'd7;
        bus.delta_i              = 32'd5;
        cyc(1);
        bus.smp_valid_i[2] = 1'b0;
        cyc(2);
        check("t7_in_wb", bus.state_o, S_WB);
        cfg(2, 32'd50);
        cyc(3);
        send(2, 32'd30, 32'd0);
        cyc(6);
        check("t7_evt", last_evt(), 4'b0100);

        // Asynchronous reset while an event is pending
        cfg(1, 32'd40);
        cyc(1);
        bus.evt_ready_i = 1'b0;
        e0 = n_evt;
        send(1, 32'd90, 32'd1);
        cyc(1);
        check("t8_pre_valid", bus.evt_valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t8_valid_drop", bus.evt_valid_o, 1'b0);
        check("t8_busy_drop", bus.busy_o, 1'b0);
        check("t8_state", bus.state_o, S_IDLE);
        cyc(2);
        rst_n           = 1'b1;
        bus.evt_ready_i = 1'b1;
        cyc(2);
        send(1, 32'd0, 32'd0);
        cyc(6);
        check("t8_evt_cnt", n_evt, e0 + 1);
        check("t8_evt", last_evt(), 4'b0011);

        cyc(4);
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
